// File: rtl/countdown_timer_4bit.sv
// countdown_timer_4bit: loadable 4-bit down-counter with start/pause button and done flag
//   clk      : system clock, all state on rising edge
//   clear_n  : asynchronous active-low reset
//   load_val : switch value captured on a load event
//   load     : raw load push-button, one event per rising edge
//   start    : raw start/pause push-button, one event per rising edge
//   count    : current count, registered
//   running  : high while counting (RUN)
//   done     : high once the count has expired (DONE)
module countdown_timer_4bit #(
    parameter int DIV_WIDTH = 27
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [3:0] load_val,
    input  logic       load,
    input  logic       start,
    output logic [3:0] count,
    output logic       running,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t               state;
    logic [2:0]           load_sync;
    logic [2:0]           start_sync;
    logic [DIV_WIDTH-1:0] presc;
    logic                 load_ev;
    logic                 start_ev;
    logic                 tick;
    // synchroniser flops reset to 1 so a button held through reset yields no edge
    assign load_ev  = load_sync[1] & ~load_sync[2];
    assign start_ev = start_sync[1] & ~start_sync[2];
    assign tick     = (state == RUN) & (&presc);
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            load_sync  <= '1;
            start_sync <= '1;
            presc      <= '0;
            count      <= '0;
            state      <= IDLE;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            load_sync  <= {load_sync[1:0], load};
            start_sync <= {start_sync[1:0], start};
            // a load event beats any start event or tick in the same cycle
            if (load_ev) begin
                count   <= load_val;
                presc   <= '0;
                state   <= IDLE;
                running <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ev && count != 4'd0) begin
                            state   <= RUN;
                            presc   <= '0;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        presc <= presc + 1'b1;
                        if (tick && count <= 4'd1) begin
                            count   <= '0;
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            if (tick)
                                count <= count - 4'd1;
                            if (start_ev) begin
                                state   <= PAUSE;
                                running <= 1'b0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start_ev) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
